// File: rtl/reset_sequencer_if.sv
// Signal bundle between the PLL/software side and reset_sequencer.
// The slave modport is the sequencer's view; master is the driver/observer side.
interface reset_sequencer_if #(
    parameter int NumOut = 4
);
    logic              locked_in;
    logic              sw_rst_req;
    logic [NumOut-1:0] rst_out;
    logic              all_done;
    logic [7:0]        lock_loss_cnt;

    modport master (
        output locked_in,
        output sw_rst_req,
        input  rst_out,
        input  all_done,
        input  lock_loss_cnt
    );

    modport slave (
        input  locked_in,
        input  sw_rst_req,
        output rst_out,
        output all_done,
        output lock_loss_cnt
    );
endinterface

// File: rtl/reset_sequencer.sv
// Synchronises PLL lock, holds resets, then releases NumOut domain resets in order.
// Optional RST_SEQ_LOCK_FILTER_EN: lock loss only after 4 consecutive low lock samples.
module reset_sequencer #(
    parameter int NumOut     = 4,
    parameter int SyncDepth  = 4,
    parameter int HoldCycles = 1024,
    parameter int StepCycles = 256,
    parameter int CntWidth   = 16
) (
    input  logic              clk,
    input  logic              rst,
    reset_sequencer_if.slave  bus
);
    localparam int IdxW = (NumOut > 1) ? $clog2(NumOut) : 1;
    localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HoldCycles - 1);
    localparam logic [CntWidth-1:0] StepLast = CntWidth'(StepCycles - 1);
    localparam logic [IdxW-1:0]     LastIdx  = IdxW'(NumOut - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } state_t;

    state_t               state;
    logic [SyncDepth-1:0] sync_q;
    logic                 lock_s;
    logic                 lock_lost;
    logic [CntWidth-1:0]  counter;
    logic [IdxW-1:0]      idx;
    logic [NumOut-1:0]    rst_q;
    logic                 done_q;
    logic [7:0]           loss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncDepth-2:0], bus.locked_in};
        end
    end

    assign lock_s = sync_q[SyncDepth-1];

`ifdef RST_SEQ_LOCK_FILTER_EN
    // Counts consecutive low lock samples while sequencing; the 4th low sample is a real loss.
    logic [1:0] drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (state == WAIT_LOCK || lock_s) begin
            drop_cnt <= '0;
        end else if (drop_cnt != 2'd3) begin
            drop_cnt <= drop_cnt + 2'd1;
        end
    end

    assign lock_lost = !lock_s && (drop_cnt == 2'd3);
`else
    assign lock_lost = !lock_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            counter  <= '0;
            idx      <= '0;
            rst_q    <= '1;
            done_q   <= 1'b0;
            loss_cnt <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_q   <= '1;
                    done_q  <= 1'b0;
                    counter <= '0;
                    idx     <= '0;
                    if (lock_s) begin
                        state <= HOLD;
                    end
                end
                default: begin
                    // Lock loss outranks a simultaneous software request.
                    if (lock_lost) begin
                        state   <= WAIT_LOCK;
                        rst_q   <= '1;
                        done_q  <= 1'b0;
                        counter <= '0;
                        idx     <= '0;
                        if (loss_cnt != 8'hFF) begin
                            loss_cnt <= loss_cnt + 8'd1;
                        end
                    end else if (bus.sw_rst_req) begin
                        state   <= HOLD;
                        rst_q   <= '1;
                        done_q  <= 1'b0;
                        counter <= '0;
                        idx     <= '0;
                    end else if (state == HOLD) begin
                        if (counter == HoldLast) begin
                            rst_q   <= rst_q << 1;
                            counter <= '0;
                            idx     <= IdxW'(1);
                            if (NumOut == 1) begin
                                state  <= RUN;
                                done_q <= 1'b1;
                            end else begin
                                state <= RELEASE;
                            end
                        end else begin
                            counter <= counter + CntWidth'(1);
                        end
                    end else if (state == RELEASE) begin
                        // Shifting in zeros from bit 0 keeps releases strictly in order.
                        if (counter == StepLast) begin
                            rst_q   <= rst_q << 1;
                            counter <= '0;
                            if (idx == LastIdx) begin
                                state  <= RUN;
                                done_q <= 1'b1;
                            end else begin
                                idx <= idx + IdxW'(1);
                            end
                        end else begin
                            counter <= counter + CntWidth'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rst_out       = rst_q;
    assign bus.all_done      = done_q;
    assign bus.lock_loss_cnt = loss_cnt;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (NumOut=4, SyncDepth=2, HoldCycles=8, StepCycles=4).
// Expected release edges come from the hold/step timing, counted from each stimulus change.
module tb_reset_sequencer;
    localparam int NumOut     = 4;
    localparam int SyncDepth  = 2;
    localparam int HoldCycles = 8;
    localparam int StepCycles = 4;
    localparam int LockToFirst  = SyncDepth + HoldCycles + 1;
    localparam int PulseToFirst = HoldCycles + 1;
    localparam int LastOffset   = StepCycles * (NumOut - 1);
`ifdef RST_SEQ_LOCK_FILTER_EN
    localparam int DetectLag = 4;
`else
    localparam int DetectLag = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NumOut(NumOut)) bus ();

    reset_sequencer #(
        .NumOut    (NumOut),
        .SyncDepth (SyncDepth),
        .HoldCycles(HoldCycles),
        .StepCycles(StepCycles),
        .CntWidth  (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic lock, input logic sw);
        bus.locked_in  = lock;
        bus.sw_rst_req = sw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] expMask(input int first, input int n);
        logic [3:0] m;
        for (int k = 0; k < NumOut; k++) begin
            m[k] = (n < first + StepCycles * k);
        end
        return m;
    endfunction

    // n counts edges since the stimulus change; bit k must be low from edge first + k*StepCycles.
    task automatic runSequence(input int first, input int start_n, input int stop_n);
        for (int n = start_n; n <= stop_n; n++) begin
            tick();
            bus.sw_rst_req = 1'b0;
            checkOutput($sformatf("seq%0d_n%0d_rst_out", first, n), 32'(bus.rst_out), 32'(expMask(first, n)));
            checkOutput($sformatf("seq%0d_n%0d_all_done", first, n), 32'(bus.all_done),
                        32'(n >= first + LastOffset));
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("reset_rst_out", 32'(bus.rst_out), 32'hF);
        checkOutput("reset_all_done", 32'(bus.all_done), 32'h0);
        checkOutput("reset_cnt", 32'(bus.lock_loss_cnt), 32'h0);

        rst = 1'b0;
        repeat (4) tick();
        checkOutput("nolock_rst_out", 32'(bus.rst_out), 32'hF);
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("wait_sw_rst_out", 32'(bus.rst_out), 32'hF);
        checkOutput("wait_sw_cnt", 32'(bus.lock_loss_cnt), 32'h0);

        applyStimulus(1'b1, 1'b0);
        runSequence(LockToFirst, 1, LockToFirst + LastOffset);
        checkOutput("powerup_cnt", 32'(bus.lock_loss_cnt), 32'h0);

`ifndef RST_SEQ_LOCK_FILTER_EN
        applyStimulus(1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("loss_pre_rst_out", 32'(bus.rst_out), 32'h0);
        checkOutput("loss_pre_all_done", 32'(bus.all_done), 32'h1);
        tick();
        checkOutput("loss_rst_out", 32'(bus.rst_out), 32'hF);
        checkOutput("loss_all_done", 32'(bus.all_done), 32'h0);
        checkOutput("loss_cnt", 32'(bus.lock_loss_cnt), 32'h1);
        applyStimulus(1'b1, 1'b0);
        runSequence(LockToFirst, 1, LockToFirst + LastOffset);
`else
        applyStimulus(1'b0, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b1, 1'b0);
        repeat (4) tick();
        checkOutput("short_drop_rst_out", 32'(bus.rst_out), 32'h0);
        checkOutput("short_drop_all_done", 32'(bus.all_done), 32'h1);
        checkOutput("short_drop_cnt", 32'(bus.lock_loss_cnt), 32'h0);
        applyStimulus(1'b0, 1'b0);
        repeat (4) tick();
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("filt_pre_rst_out", 32'(bus.rst_out), 32'h0);
        tick();
        checkOutput("filt_loss_rst_out", 32'(bus.rst_out), 32'hF);
        checkOutput("filt_loss_all_done", 32'(bus.all_done), 32'h0);
        checkOutput("filt_loss_cnt", 32'(bus.lock_loss_cnt), 32'h1);
        runSequence(LockToFirst, 3, LockToFirst + LastOffset);
`endif

        // Software reset from RUN, stopped while rst_out is 4'b1100, then again from RELEASE.
        applyStimulus(1'b1, 1'b1);
        runSequence(PulseToFirst, 1, PulseToFirst + StepCycles + 1);
        checkOutput("sw_mid_rst_out", 32'(bus.rst_out), 32'hC);
        applyStimulus(1'b1, 1'b1);
        runSequence(PulseToFirst, 1, PulseToFirst + LastOffset);
        checkOutput("sw_cnt", 32'(bus.lock_loss_cnt), 32'h1);

        applyStimulus(1'b0, 1'b0);
        repeat (1 + DetectLag) tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("simul_rst_out", 32'(bus.rst_out), 32'hF);
        checkOutput("simul_all_done", 32'(bus.all_done), 32'h0);
        checkOutput("simul_cnt", 32'(bus.lock_loss_cnt), 32'h2);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0);
        repeat (6) tick();
        checkOutput("wait_sw2_rst_out", 32'(bus.rst_out), 32'hF);
        checkOutput("wait_sw2_cnt", 32'(bus.lock_loss_cnt), 32'h2);
        applyStimulus(1'b1, 1'b0);
        runSequence(LockToFirst, 1, LockToFirst + LastOffset);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0);
            repeat (5) tick();
            applyStimulus(1'b1, 1'b0);
            repeat (4) tick();
            if (i == 99) begin
                checkOutput("sat_mid_cnt", 32'(bus.lock_loss_cnt), 32'd102);
            end
        end
        checkOutput("sat_cnt", 32'(bus.lock_loss_cnt), 32'd255);

        // Asynchronous reset between clock edges, first in HOLD, then in RUN.
        #2 rst = 1'b1;
        #1;
        checkOutput("async_hold_rst_out", 32'(bus.rst_out), 32'hF);
        checkOutput("async_hold_all_done", 32'(bus.all_done), 32'h0);
        checkOutput("async_hold_cnt", 32'(bus.lock_loss_cnt), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        runSequence(LockToFirst, 1, LockToFirst + LastOffset);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_run_rst_out", 32'(bus.rst_out), 32'hF);
        checkOutput("async_run_all_done", 32'(bus.all_done), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
